// File: rtl/boot_loader_if.sv
// Byte-stream and memory-write bundle of the boot loader.
// master = loader side, slave = upstream source / memory side.
interface boot_loader_if #(
    parameter int unsigned ADDRWIDTH = 16
) ();
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 mem_write;
    logic                 mem_select;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 core_nreset;
    logic                 busy;
    logic                 error;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_write, mem_select, mem_addr, mem_wdata,
               core_nreset, busy, error
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_write, mem_select, mem_addr, mem_wdata,
               core_nreset, busy, error
    );
endinterface

// File: rtl/boot_loader.sv
// Framed byte-stream loader: fills instruction ROM / data RAM, holds the core in reset until RUN.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to every load frame.
module boot_loader #(
    parameter int unsigned ADDRWIDTH = 16
) (
    input  logic          clock,
    input  logic          nreset,
    boot_loader_if.master bus
);
    localparam int unsigned WORDW = 32;
    localparam int unsigned BYTEW = 8;
    localparam int unsigned IDXW  = 2;

    localparam logic [BYTEW-1:0] CMD_ROM = 8'h01;
    localparam logic [BYTEW-1:0] CMD_RAM = 8'h02;
    localparam logic [BYTEW-1:0] CMD_RUN = 8'h03;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE, CNT0, CNT1, ADR0, ADR1, DATA, WRITE, CHK, RUN
    } state_e;
    localparam state_e LAST_ST = CHK;
`else
    typedef enum logic [3:0] {
        IDLE, CNT0, CNT1, ADR0, ADR1, DATA, WRITE, RUN
    } state_e;
    localparam state_e LAST_ST = IDLE;
`endif

    state_e               state_q, state_d;
    logic                 sel_q, sel_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
    logic [BYTEW-1:0]     lo_q, lo_d;
    logic [WORDW-1:0]     wdata_q, wdata_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic                 err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTEW-1:0]     xor_q, xor_d;
`endif

    logic rx_ready_c;
    logic busy_c;
    logic accept;

    // Handshake and status are pure decodes of the registered state.
    assign rx_ready_c = (state_q != WRITE) && (state_q != RUN);
    assign busy_c     = (state_q != IDLE) && (state_q != RUN);
    assign accept     = bus.rx_valid && rx_ready_c;

    assign bus.rx_ready    = rx_ready_c;
    assign bus.busy        = busy_c;
    assign bus.mem_write   = (state_q == WRITE);
    assign bus.core_nreset = (state_q == RUN);
    assign bus.mem_select  = sel_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.error       = err_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif

        case (state_q)
            IDLE: begin
                idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
                xor_d = '0;
`endif
                if (accept) begin
                    case (bus.rx_data)
                        CMD_ROM: begin
                            sel_d   = 1'b0;
                            state_d = CNT0;
                        end
                        CMD_RAM: begin
                            sel_d   = 1'b1;
                            state_d = CNT0;
                        end
                        CMD_RUN: state_d = RUN;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            CNT0: if (accept) begin
                lo_d    = bus.rx_data;
                state_d = CNT1;
            end
            CNT1: if (accept) begin
                cnt_d   = ADDRWIDTH'({bus.rx_data, lo_q});
                state_d = ADR0;
            end
            ADR0: if (accept) begin
                lo_d    = bus.rx_data;
                state_d = ADR1;
            end
            ADR1: if (accept) begin
                addr_d  = ADDRWIDTH'({bus.rx_data, lo_q});
                state_d = (cnt_q == '0) ? LAST_ST : DATA;
            end
            // Bytes arrive LSB first, so shift in from the top.
            DATA: if (accept) begin
                wdata_d = {bus.rx_data, wdata_q[WORDW-1:BYTEW]};
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(3)) state_d = WRITE;
            end
            WRITE: begin
                cnt_d = cnt_q - ADDRWIDTH'(1);
                if (cnt_q != ADDRWIDTH'(1)) begin
                    addr_d  = addr_q + ADDRWIDTH'(1);
                    state_d = DATA;
                end else begin
                    state_d = LAST_ST;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: if (accept) begin
                if (bus.rx_data != xor_q) err_d = 1'b1;
                state_d = IDLE;
            end
`endif
            RUN: state_d = RUN;
            default: state_d = IDLE;
        endcase

`ifdef LOADER_CHECKSUM_EN
        // Running XOR over every field byte after the command byte.
        if (accept && busy_c && (state_q != CHK)) xor_d = xor_q ^ bus.rx_data;
`endif
    end
endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table of load frames plus reset, checksum and RUN sequences.
module tb_boot_loader;
    localparam int unsigned AW = 16;

    logic clock  = 1'b0;
    logic nreset = 1'b0;
    longint unsigned cycle = 0;
    int checks = 0;
    int errors = 0;

    boot_loader_if #(.ADDRWIDTH(AW)) bus ();
    boot_loader #(.ADDRWIDTH(AW)) dut (.clock(clock), .nreset(nreset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] cnt;
        logic [15:0] addr;
        logic [31:0] w0, w1, w2;
        int          gaps;
        int          nwr;
        logic        sel;
        logic [15:0] ea0, ea1, ea2;
        logic        err;
    } vec_t;

    typedef struct {
        logic            sel;
        logic [15:0]     a;
        logic [31:0]     d;
        longint unsigned cyc;
    } wr_t;

    wr_t  wq[$];
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Capture every write strobe; upstream must be stalled while it is high.
    always @(negedge clock) begin
        if (bus.mem_write === 1'b1) begin
            wq.push_back('{bus.mem_select, bus.mem_addr, bus.mem_wdata, cycle});
            chk("ready_low_in_write", 32'(bus.rx_ready), 32'd0);
        end
    end

    task automatic reset_pulse();
        @(negedge clock);
        bus.rx_valid = 1'b0;
        nreset = 1'b0;
        #2;
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_select", 32'(bus.mem_select), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_core_nreset", 32'(bus.core_nreset), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        @(negedge clock);
        nreset = 1'b1;
    endtask

    // Present one byte after an optional idle gap; returns after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            bus.rx_valid = 1'b0;
        end
        @(negedge clock);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        #1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout actual=ready_low expected=ready_high byte=0x%0h", b);
        end
        @(posedge clock);
    endtask

    task automatic send_frame(input vec_t v, input bit bad_chk);
        logic [7:0]  q[$];
        logic [31:0] w;
        logic [7:0]  x;
        q.push_back(v.cmd);
        if (v.cmd == 8'h01 || v.cmd == 8'h02) begin
            q.push_back(v.cnt[7:0]);
            q.push_back(v.cnt[15:8]);
            q.push_back(v.addr[7:0]);
            q.push_back(v.addr[15:8]);
            for (int i = 0; i < int'(v.cnt); i++) begin
                w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : v.w2;
                for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
            end
`ifdef LOADER_CHECKSUM_EN
            x = 8'h00;
            for (int k = 1; k < q.size(); k++) x = x ^ q[k];
            q.push_back(bad_chk ? ~x : x);
`else
            x = 8'h00;
            if (bad_chk) q.push_back(x);
`endif
        end
        for (int k = 0; k < q.size(); k++)
            send_byte(q[k], (v.gaps != 0) ? int'($urandom_range(0, 3)) : 0);
        @(negedge clock);
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit bad_chk);
        logic [15:0] ea;
        wq.delete();
        send_frame(v, bad_chk);
        #1;
        chk({tag, "_nwrites"}, 32'(wq.size()), 32'(v.nwr));
        for (int j = 0; j < wq.size() && j < v.nwr; j++) begin
            ea = (j == 0) ? v.ea0 : (j == 1) ? v.ea1 : v.ea2;
            chk($sformatf("%s_sel%0d", tag, j), 32'(wq[j].sel), 32'(v.sel));
            chk($sformatf("%s_addr%0d", tag, j), 32'(wq[j].a), 32'(ea));
            chk($sformatf("%s_data%0d", tag, j), wq[j].d,
                (j == 0) ? v.w0 : (j == 1) ? v.w1 : v.w2);
        end
        chk({tag, "_error"}, 32'(bus.error), 32'(v.err));
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_ready"}, 32'(bus.rx_ready), 32'd1);
        chk({tag, "_core_nreset"}, 32'(bus.core_nreset), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        //        cmd    cnt     addr      w0            w1            w2           gaps nwr sel ea0       ea1       ea2      err
        vt[0] = '{8'h01, 16'd2, 16'h0000, 32'h00500013, 32'h00100093, 32'h0,       0, 2, 1'b0, 16'h0000, 16'h0001, 16'h0,   1'b0};
        vt[1] = '{8'h02, 16'd1, 16'hFFFF, 32'hDEADBEEF, 32'h0,        32'h0,       0, 1, 1'b1, 16'hFFFF, 16'h0,    16'h0,   1'b0};
        vt[2] = '{8'h02, 16'd2, 16'hFFFF, 32'h11223344, 32'h55667788, 32'h0,       0, 2, 1'b1, 16'hFFFF, 16'h0000, 16'h0,   1'b0};
        vt[3] = '{8'h07, 16'd0, 16'h0000, 32'h0,        32'h0,        32'h0,       0, 0, 1'b0, 16'h0,    16'h0,    16'h0,   1'b1};
        vt[4] = '{8'h01, 16'd1, 16'h0010, 32'hCAFEF00D, 32'h0,        32'h0,       0, 1, 1'b0, 16'h0010, 16'h0,    16'h0,   1'b1};
        vt[5] = '{8'hFF, 16'd0, 16'h0000, 32'h0,        32'h0,        32'h0,       0, 0, 1'b0, 16'h0,    16'h0,    16'h0,   1'b1};
        vt[6] = '{8'h02, 16'd0, 16'h1234, 32'h0,        32'h0,        32'h0,       0, 0, 1'b0, 16'h0,    16'h0,    16'h0,   1'b1};
        vt[7] = '{8'h02, 16'd3, 16'h0100, 32'hA5A55A5A, 32'h01234567, 32'h89ABCDEF, 1, 3, 1'b1, 16'h0100, 16'h0101, 16'h0102, 1'b1};

        reset_pulse();

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i], 1'b0);
            if (i == 0 && wq.size() == 2)
                chk("vec0_throughput", 32'(wq[1].cyc - wq[0].cyc), 32'd5);
        end

        // Reset in the middle of a word: nothing written, then a clean frame loads.
        wq.delete();
        send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h20, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        reset_pulse();
        repeat (2) @(negedge clock);
        chk("midreset_nwrites", 32'(wq.size()), 32'd0);
        v = '{8'h01, 16'd1, 16'h0020, 32'h01020304, 32'h0, 32'h0, 0, 1, 1'b0, 16'h0020, 16'h0, 16'h0, 1'b0};
        run_vec("post_reset", v, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        v = '{8'h02, 16'd1, 16'h0040, 32'h0BADC0DE, 32'h0, 32'h0, 0, 1, 1'b1, 16'h0040, 16'h0, 16'h0, 1'b1};
        run_vec("bad_checksum", v, 1'b1);
`endif

        // RUN releases the core and the loader stops accepting bytes.
        wq.delete();
        send_byte(8'h03, 0);
        @(negedge clock);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h01;
        #1;
        chk("run_core_nreset", 32'(bus.core_nreset), 32'd1);
        chk("run_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("run_busy", 32'(bus.busy), 32'd0);
        repeat (10) @(negedge clock);
        #1;
        chk("run_hold_core_nreset", 32'(bus.core_nreset), 32'd1);
        chk("run_hold_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("run_hold_busy", 32'(bus.busy), 32'd0);
        chk("run_no_writes", 32'(wq.size()), 32'd0);
        bus.rx_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
